bcd_score_display: RTL and testbench

BCD_SCORE_DISPLAY -- requirements
Module: bcd_score_display

---
 rtl/bcd_score_display_pkg.sv | 42 ++++
 rtl/bcd_score_display_digit_add.sv | 27 ++
 rtl/bcd_score_display.sv | 125 ++++++++++++
 tb/tb_bcd_score_display.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/bcd_score_display_pkg.sv
// Shared definitions for the BCD score display: digit and segment types,
// the seven-segment code table, the blank pattern and the digit-count limit.
package bcd_score_display_pkg;

  localparam int MAX_DIGITS = 8;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  // Segment order is {a,b,c,d,e,f,g}, a in the MSB, 1 = segment lit.
  localparam seg_t SEG_BLANK = 7'b0000000;
  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;

  // Non-BCD nibbles never light anything, so a corrupted digit shows dark.
  function automatic seg_t segEncode(input bcd_t digit);
    seg_t pattern;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/bcd_score_display_digit_add.sv
// One decimal digit of the score adder: digit + addend + carry-in, folded
// back into 0..9 with a carry-out. Inputs are at most 9 + 9 + 1, so a
// single subtract-ten correction is always enough.
module bcd_digit_add
  import bcd_score_display_pkg::*;
(
  input  bcd_t i_digit,
  input  bcd_t i_addend,
  input  logic i_carry,
  output bcd_t o_sum,
  output logic o_carry
);

  logic [4:0] w_raw;

  // Binary add, then wrap anything above nine into the next decade.
  always_comb begin
    w_raw   = 5'(i_digit) + 5'(i_addend) + 5'(i_carry);
    o_sum   = w_raw[3:0];
    o_carry = 1'b0;
    if (w_raw > 5'd9) begin
      o_sum   = 4'(w_raw - 5'd10);
      o_carry = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_score_display.sv
// Saturating BCD score counter with a multiplexed seven-segment driver.
// The score adds a clamped 0..9 amount through a rippled chain of digit
// adders; the scanner walks positions from MSD down to LSD, registering
// one common select and one segment pattern per scan tick.
module bcd_score_display
  import bcd_score_display_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 4,
  parameter int BLANK_LEADING  = 1,
  parameter int COM_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    score_up,
  input  logic [3:0]              add_val,
  input  logic                    clear,
  output logic [NUM_DIGITS-1:0]   com,
  output logic [6:0]              seg,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    saturated
);

  localparam int                    PTR_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PTR_W-1:0]      PTR_MAX  = PTR_W'(NUM_DIGITS - 1);
  localparam logic [15:0]           DIV_MAX  = 16'(SCAN_DIV - 1);
  localparam logic [NUM_DIGITS-1:0] COM_IDLE = {NUM_DIGITS{COM_ACTIVE_LOW != 0}};

  bcd_t                  r_digit [NUM_DIGITS];
  logic                  r_sat;
  logic [15:0]           r_div;
  logic [PTR_W-1:0]      r_ptr;
  logic [NUM_DIGITS-1:0] r_com;
  seg_t                  r_seg;

  bcd_t                  w_addend;
  bcd_t                  w_sum [NUM_DIGITS];
  logic [NUM_DIGITS:0]   w_carry;
  logic [NUM_DIGITS-1:0] w_zeroFromHere;
  logic [NUM_DIGITS-1:0] w_comOneHot;
  logic                  w_tick;
  logic                  w_selBlank;
  bcd_t                  w_selDigit;
  seg_t                  w_selSeg;

  assign w_addend   = (add_val > 4'd9) ? 4'd9 : add_val;
  assign w_carry[0] = 1'b0;

  // Only the LSD sees the addend; higher digits just absorb the carry.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_add
    bcd_digit_add u_add (
      .i_digit (r_digit[gi]),
      .i_addend((gi == 0) ? w_addend : 4'd0),
      .i_carry (w_carry[gi]),
      .o_sum   (w_sum[gi]),
      .o_carry (w_carry[gi+1])
    );
  end

  // A set bit means this digit and every digit above it are zero,
  // which is exactly the leading-zero blanking condition.
  always_comb begin
    w_zeroFromHere = '0;
    w_zeroFromHere[NUM_DIGITS-1] = (r_digit[NUM_DIGITS-1] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      w_zeroFromHere[i] = (r_digit[i] == 4'd0) && w_zeroFromHere[i+1];
    end
  end

  assign w_tick      = (r_div == DIV_MAX);
  assign w_selDigit  = r_digit[r_ptr];
  assign w_selBlank  = (BLANK_LEADING != 0) && (r_ptr != '0) && w_zeroFromHere[r_ptr];
  assign w_selSeg    = w_selBlank ? SEG_BLANK : segEncode(w_selDigit);
  assign w_comOneHot = NUM_DIGITS'(1) << r_ptr;

  // Score register: clear beats add, and an overflowing add pins the
  // score at all nines and latches the saturated flag until cleared.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= 4'd0;
      r_sat <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= 4'd0;
      r_sat <= 1'b0;
    end else if (score_up && !r_sat) begin
      if (w_carry[NUM_DIGITS]) begin
        for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= 4'd9;
        r_sat <= 1'b1;
      end else begin
        for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= w_sum[i];
      end
    end
  end

  // Scanner: on each divider wrap, latch the current position's drive
  // from the pre-edge score and step the pointer toward the LSD.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div <= 16'd0;
      r_ptr <= PTR_MAX;
      r_com <= COM_IDLE;
      r_seg <= SEG_BLANK;
    end else if (w_tick) begin
      r_div <= 16'd0;
      r_com <= (COM_ACTIVE_LOW != 0) ? ~w_comOneHot : w_comOneHot;
      r_seg <= w_selSeg;
      r_ptr <= (r_ptr == '0) ? PTR_MAX : r_ptr - PTR_W'(1);
    end else begin
      r_div <= r_div + 16'd1;
    end
  end

  // Flatten the digit registers onto the output bus, LSD in nibble 0.
  always_comb begin
    digits = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digits[4*i +: 4] = r_digit[i];
    end
  end

  assign com       = r_com;
  assign seg       = r_seg;
  assign saturated = r_sat;

endmodule

// File: tb/tb_bcd_score_display.sv
// Directed bench for bcd_score_display: an 8-digit instance with a
// three-cycle scan, and a 2-digit instance with a one-cycle scan used
// for saturation behaviour.
module tb_bcd_score_display;

  logic        clk = 1'b0;

  logic        rstA, upA, clrA;
  logic [3:0]  valA;
  logic [7:0]  comA;
  logic [6:0]  segA;
  logic [31:0] digA;
  logic        satA;

  logic        rstB, upB, clrB;
  logic [3:0]  valB;
  logic [1:0]  comB;
  logic [6:0]  segB;
  logic [7:0]  digB;
  logic        satB;

  int checks = 0;
  int errors = 0;

  logic [7:0] expComTab [8];
  logic [6:0] expSegTab [8];

  bcd_score_display #(
    .NUM_DIGITS(8), .SCAN_DIV(3), .BLANK_LEADING(1), .COM_ACTIVE_LOW(1)
  ) dutA (
    .clk(clk), .rst(rstA), .score_up(upA), .add_val(valA), .clear(clrA),
    .com(comA), .seg(segA), .digits(digA), .saturated(satA)
  );

  bcd_score_display #(
    .NUM_DIGITS(2), .SCAN_DIV(1), .BLANK_LEADING(1), .COM_ACTIVE_LOW(1)
  ) dutB (
    .clk(clk), .rst(rstB), .score_up(upB), .add_val(valB), .clear(clrB),
    .com(comB), .seg(segB), .digits(digB), .saturated(satB)
  );

  // Free-running 10 ns clock shared by both instances.
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive the 8-digit instance for one edge.
  task automatic applyStimulus(input logic r, input logic up, input logic [3:0] val, input logic clr);
    rstA = r; upA = up; valA = val; clrA = clr;
    step();
  endtask

  // Drive the 2-digit instance for one edge.
  task automatic applyStimulusSmall(input logic r, input logic up, input logic [3:0] val, input logic clr);
    rstB = r; upB = up; valB = val; clrB = clr;
    step();
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Linear directed sequence covering reset, adds, clear, scan and saturation.
  initial begin
    expComTab = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    expSegTab = '{7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000,
                  7'b0000000, 7'b0000000, 7'b0110011, 7'b1101101};

    rstA = 1'b0; upA = 1'b0; valA = 4'd0; clrA = 1'b0;
    rstB = 1'b0; upB = 1'b0; valB = 4'd0; clrB = 1'b0;
    step();
    step();
    $display("[TB] reset state");
    checkOutput("rst_digits", digA, 32'h0);
    checkOutput("rst_sat", {31'd0, satA}, 32'd0);
    checkOutput("rst_com", {24'd0, comA}, 32'hFF);
    checkOutput("rst_seg", {25'd0, segA}, 32'h0);

    $display("[TB] basic adds, clamp, zero add, clear priority");
    applyStimulus(1'b1, 1'b1, 4'd7, 1'b0);
    checkOutput("add7_once", digA, 32'h7);
    applyStimulus(1'b1, 1'b1, 4'd7, 1'b0);
    checkOutput("add7_twice", digA, 32'h14);
    checkOutput("add7_sat", {31'd0, satA}, 32'd0);
    checkOutput("pre_tick_com", {24'd0, comA}, 32'hFF);
    applyStimulus(1'b1, 1'b1, 4'd12, 1'b0);
    checkOutput("clamp_add", digA, 32'h23);
    checkOutput("first_tick_com", {24'd0, comA}, 32'h7F);
    checkOutput("first_tick_seg", {25'd0, segA}, 32'h0);
    applyStimulus(1'b1, 1'b1, 4'd0, 1'b0);
    checkOutput("zero_add", digA, 32'h23);
    applyStimulus(1'b1, 1'b1, 4'd5, 1'b1);
    checkOutput("clear_priority", digA, 32'h0);
    checkOutput("clear_sat", {31'd0, satA}, 32'd0);

    $display("[TB] carry ripple across several digits");
    for (int i = 0; i < 111; i++) applyStimulus(1'b1, 1'b1, 4'd9, 1'b0);
    checkOutput("reach_999", digA, 32'h999);
    applyStimulus(1'b1, 1'b1, 4'd1, 1'b0);
    checkOutput("ripple_1000", digA, 32'h1000);

    $display("[TB] reset mid-scan and mid-update");
    applyStimulus(1'b0, 1'b1, 4'd9, 1'b0);
    checkOutput("midrst_digits", digA, 32'h0);
    checkOutput("midrst_com", {24'd0, comA}, 32'hFF);
    checkOutput("midrst_seg", {25'd0, segA}, 32'h0);
    checkOutput("midrst_sat", {31'd0, satA}, 32'd0);

    $display("[TB] scan of score 42");
    for (int c = 1; c <= 24; c++) begin
      if (c <= 4)      applyStimulus(1'b1, 1'b1, 4'd9, 1'b0);
      else if (c == 5) applyStimulus(1'b1, 1'b1, 4'd6, 1'b0);
      else             applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
      if (c < 3) begin
        checkOutput("scan_idle_com", {24'd0, comA}, 32'hFF);
        checkOutput("scan_idle_seg", {25'd0, segA}, 32'h0);
      end else begin
        checkOutput("scan_com", {24'd0, comA}, {24'd0, expComTab[c/3 - 1]});
        checkOutput("scan_seg", {25'd0, segA}, {25'd0, expSegTab[c/3 - 1]});
      end
    end
    checkOutput("scan_score", digA, 32'h42);

    $display("[TB] two-digit saturation");
    applyStimulusSmall(1'b1, 1'b1, 4'd9, 1'b0);
    checkOutput("small_first_com", {30'd0, comB}, 32'h1);
    checkOutput("small_first_seg", {25'd0, segB}, 32'h0);
    checkOutput("small_first_dig", {24'd0, digB}, 32'h09);
    applyStimulusSmall(1'b1, 1'b1, 4'd9, 1'b0);
    checkOutput("small_lsd_com", {30'd0, comB}, 32'h2);
    checkOutput("small_lsd_seg", {25'd0, segB}, 32'h7B);
    checkOutput("small_18", {24'd0, digB}, 32'h18);
    for (int i = 0; i < 8; i++) applyStimulusSmall(1'b1, 1'b1, 4'd9, 1'b0);
    applyStimulusSmall(1'b1, 1'b1, 4'd5, 1'b0);
    checkOutput("small_95", {24'd0, digB}, 32'h95);
    checkOutput("small_95_sat", {31'd0, satB}, 32'd0);
    applyStimulusSmall(1'b1, 1'b1, 4'd9, 1'b0);
    checkOutput("small_sat_dig", {24'd0, digB}, 32'h99);
    checkOutput("small_sat_flag", {31'd0, satB}, 32'd1);
    applyStimulusSmall(1'b1, 1'b1, 4'd1, 1'b0);
    checkOutput("small_hold_dig", {24'd0, digB}, 32'h99);
    checkOutput("small_hold_flag", {31'd0, satB}, 32'd1);
    applyStimulusSmall(1'b1, 1'b1, 4'd4, 1'b1);
    checkOutput("small_clear_dig", {24'd0, digB}, 32'h00);
    checkOutput("small_clear_flag", {31'd0, satB}, 32'd0);
    applyStimulusSmall(1'b1, 1'b1, 4'd3, 1'b0);
    checkOutput("small_after_clear", {24'd0, digB}, 32'h03);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
